uart_rx: RTL and testbench

UART receiver: recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from the serial line. Baud rate is selected through the same 4-bit `mode` table the UART transmitter uses. Each good byte is delivered through a one-entry valid/ready output register, and framing and overrun errors are flagged. The block sits between the external RX pin and the packet layer; it is the receive-side counterpart of the transmitter on the same link.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, mode-selected bit period,
// a one-entry valid/ready output register, and framing/overrun pulses.
module uart_rx #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_line,
   input  logic [3:0] mode,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t      state;
   logic [1:0]  sync;
   logic        rx_s;
   logic [31:0] clock_cnt;
   logic [3:0]  bit_cnt;
   logic [31:0] n_lat;
   logic [31:0] half;
   logic [7:0]  shift;
   logic        unused_clk_freq;

   // The bit-period table is fixed for a 50 MHz clock; CLK_FREQ is informational.
   assign unused_clk_freq = (CLK_FREQ > 0);

   assign rx_s = sync[1];
   assign half = {1'b0, n_lat[31:1]};

   function automatic logic [31:0] bit_n(input logic [3:0] m);
      case (m)
         4'd0:    bit_n = 32'd10417;
         4'd1:    bit_n = 32'd5208;
         4'd2:    bit_n = 32'd434;
         4'd3:    bit_n = 32'd195;
         default: bit_n = 32'd5208;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], rx_line};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         clock_cnt  <= '0;
         bit_cnt    <= '0;
         n_lat      <= 32'd5208;
         shift      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (data_valid && data_ready)
            data_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  n_lat     <= bit_n(mode);
                  clock_cnt <= '0;
                  bit_cnt   <= '0;
                  state     <= START;
               end
            end
            START: begin
               if (clock_cnt == half) begin
                  clock_cnt <= '0;
                  bit_cnt   <= '0;
                  state     <= rx_s ? IDLE : DATA;
               end else begin
                  clock_cnt <= clock_cnt + 32'd1;
               end
            end
            DATA: begin
               if (clock_cnt == n_lat) begin
                  shift[bit_cnt[2:0]] <= rx_s;
                  clock_cnt           <= '0;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  clock_cnt <= clock_cnt + 32'd1;
               end
            end
            STOP: begin
               if (clock_cnt == n_lat) begin
                  clock_cnt <= '0;
                  bit_cnt   <= '0;
                  if (rx_s) begin
                     // A same-cycle handshake frees the register for the new byte.
                     if (!data_valid || data_ready) begin
                        data_out   <= shift;
                        data_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  clock_cnt <= clock_cnt + 32'd1;
               end
            end
            BREAK: begin
               if (rx_s) begin
                  clock_cnt <= '0;
                  bit_cnt   <= '0;
                  state     <= IDLE;
               end
            end
            default: begin
               clock_cnt <= '0;
               bit_cnt   <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected bytes are
// queued at send time and checked against each valid/ready handshake.
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx_line;
   logic [3:0] mode;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;

   int         cyc;
   int         errors;
   int         checks;
   int         fe_cnt;
   int         ov_cnt;
   int         ov_cyc;
   int         hs_cnt;
   int         rise_cyc;
   int         last_e;
   logic       prev_valid;
   logic [7:0] exp_q[$];

   localparam int P2 = 435;
   localparam int P3 = 196;
   localparam int P1 = 5209;
   localparam int LAT2 = 4 + 217 + 9 * P2;

   uart_rx #(.CLK_FREQ(50000000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_line    (rx_line),
      .mode       (mode),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives the first nb bits of {stop, byte, start}; records the edge index at the start bit.
   task automatic send(input logic [7:0] b, input int p, input logic stopv, input int nb);
      logic [9:0] fr;
      fr     = {stopv, b, 1'b0};
      last_e = cyc;
      for (int i = 0; i < nb; i++) begin
         rx_line = fr[i];
         repeat (p) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (data_valid && !prev_valid) rise_cyc = cyc;
         prev_valid = data_valid;
         if (frame_err) fe_cnt++;
         if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
         end
         if (frame_err || overrun) chk("pulse_excl", {31'b0, frame_err & overrun}, 32'd0);
         if (data_valid && data_ready) begin
            hs_cnt++;
            chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("sb_data", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int hs0;
      int e22;
      errors = 0; checks = 0; fe_cnt = 0; ov_cnt = 0; ov_cyc = 0;
      hs_cnt = 0; rise_cyc = 0; last_e = 0; prev_valid = 1'b0;
      rst_n = 1'b0; rx_line = 1'b1; mode = 4'd2; data_ready = 1'b0;
      idle(4);
      chk("rst_valid", {31'b0, data_valid}, 32'd0);
      chk("rst_data",  {24'b0, data_out}, 32'd0);
      chk("rst_fe",    {31'b0, frame_err}, 32'd0);
      chk("rst_ov",    {31'b0, overrun}, 32'd0);
      rst_n = 1'b1;
      idle(10);

      // Single byte at mode 2; mode flips mid-frame and must be ignored.
      exp_q.push_back(8'hA5);
      fork
         send(8'hA5, P2, 1'b1, 10);
         begin
            idle(600);
            mode = 4'd0;
         end
      join
      mode = 4'd2;
      idle(5);
      chk("t1_rise",  rise_cyc, last_e + LAT2);
      chk("t1_valid", {31'b0, data_valid}, 32'd1);
      chk("t1_data",  {24'b0, data_out}, 32'h0A5);
      chk("t1_fe",    fe_cnt, 0);
      chk("t1_ov",    ov_cnt, 0);
      data_ready = 1'b1;
      idle(1);
      chk("t1_consumed", {31'b0, data_valid}, 32'd0);
      chk("t1_q", exp_q.size(), 0);

      // Back-to-back at mode 3.
      mode = 4'd3;
      hs0  = hs_cnt;
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
      send(8'h00, P3, 1'b1, 10);
      send(8'hFF, P3, 1'b1, 10);
      send(8'h3C, P3, 1'b1, 10);
      idle(50);
      chk("b2b_hs", hs_cnt, hs0 + 3);
      chk("b2b_q",  exp_q.size(), 0);
      chk("b2b_ov", ov_cnt, 0);

      // Glitch rejection.
      mode    = 4'd2;
      hs0     = hs_cnt;
      rx_line = 1'b0;
      idle(100);
      rx_line = 1'b1;
      idle(1000);
      chk("gl_hs", hs_cnt, hs0);
      chk("gl_fe", fe_cnt, 0);
      exp_q.push_back(8'h5A);
      send(8'h5A, P2, 1'b1, 10);
      idle(20);
      chk("gl_next_hs", hs_cnt, hs0 + 1);
      chk("gl_next_q",  exp_q.size(), 0);

      // Framing error followed by a held-low break.
      hs0 = hs_cnt;
      send(8'h81, P2, 1'b0, 10);
      idle(20 * P2);
      chk("fe_pulse", fe_cnt, 1);
      chk("fe_hs",    hs_cnt, hs0);
      chk("fe_valid", {31'b0, data_valid}, 32'd0);
      rx_line = 1'b1;
      idle(50);
      exp_q.push_back(8'h42);
      send(8'h42, P2, 1'b1, 10);
      idle(20);
      chk("fe_next_hs", hs_cnt, hs0 + 1);
      chk("fe_next_q",  exp_q.size(), 0);
      chk("fe_after",   fe_cnt, 1);

      // Overrun: second byte dropped while the first is held.
      data_ready = 1'b0;
      exp_q.push_back(8'h11);
      send(8'h11, P2, 1'b1, 10);
      send(8'h22, P2, 1'b1, 10);
      e22 = last_e;
      idle(20);
      chk("ov_pulse", ov_cnt, 1);
      chk("ov_time",  ov_cyc, e22 + LAT2);
      chk("ov_data",  {24'b0, data_out}, 32'h011);
      chk("ov_valid", {31'b0, data_valid}, 32'd1);
      data_ready = 1'b1;
      idle(1);
      chk("ov_consumed", {31'b0, data_valid}, 32'd0);
      chk("ov_q", exp_q.size(), 0);

      // Reset in the middle of bit 4 of a mode-1 frame.
      data_ready = 1'b0;
      mode       = 4'd1;
      send(8'h96, P1, 1'b1, 5);
      rx_line = 1'b1;
      idle(P1 / 2);
      rst_n = 1'b0;
      #1;
      chk("mr_valid", {31'b0, data_valid}, 32'd0);
      chk("mr_data",  {24'b0, data_out}, 32'd0);
      chk("mr_fe",    {31'b0, frame_err}, 32'd0);
      chk("mr_ov",    {31'b0, overrun}, 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(10);
      mode       = 4'd2;
      data_ready = 1'b1;
      hs0        = hs_cnt;
      exp_q.push_back(8'hC3);
      send(8'hC3, P2, 1'b1, 10);
      idle(20);
      chk("mr_next_hs", hs_cnt, hs0 + 1);
      chk("mr_next_q",  exp_q.size(), 0);
      chk("mr_fe_cnt",  fe_cnt, 1);
      chk("mr_ov_cnt",  ov_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
